inc_count_reg: RTL



---
 rtl/inc_count_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/inc_count_reg.sv
// ---------------------------------------------------------------------------
// inc_count_reg
//
// Registered counting stage that closes the incrementer feedback loop. Q feeds
// the incrementer and the incremented result is written back into Q every
// RUN cycle. A run starts from a captured Init value and ends once Q reaches
// a captured Limit, signalled by a one-cycle Done pulse.
//
// Ports:
//   Clk    rising-edge clock
//   Rst    synchronous, active-high reset (priority over all other inputs)
//   Start  begin a count; only looked at while idle
//   Hold   stall; freezes Q and state while counting
//   Init   start value, captured when Start is accepted
//   Limit  terminal value, captured when Start is accepted
//   Q      current count (registered)
//   Busy   high while counting
//   Done   one-cycle completion pulse
//   Wrap   sticky: the count rolled over from all-ones to zero in this run
// ---------------------------------------------------------------------------
module inc_count_reg #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Hold,
    input  logic [WIDTH-1:0] Init,
    input  logic [WIDTH-1:0] Limit,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH:0]   inc_res;

    // Incrementer datapath: the extra top bit is the carry out, which is set
    // exactly when the input was all-ones and the result rolls over to zero.
    function automatic logic [WIDTH:0] inc_wrap(input logic [WIDTH-1:0] v);
        return {1'b0, v} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    assign inc_res = inc_wrap(Q);

    // Terminal value is pure data: it is only meaningful after an accepted
    // Start, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (state == IDLE && Start) begin
            limit_r <= Limit;
        end
    end

    // Control FSM with registered Busy/Done so no input reaches an output
    // combinationally. Busy/Done are loaded with the value matching the
    // state being entered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Q     <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        Q     <= Init;
                        Wrap  <= 1'b0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!Hold) begin
                        // Limit check wins over the increment, so a run that
                        // ends on all-ones never reports a wrap.
                        if (Q == limit_r) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            Q <= inc_res[WIDTH-1:0];
                            if (inc_res[WIDTH]) begin
                                Wrap <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // Start is deliberately ignored here; it is only
                    // accepted from the following idle cycle onwards.
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
